// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types and defaults for the boot-ROM fetch arbiter.
// The state encoding is fixed so that it reads the same in waveforms and in the RTL.
package rom_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [35:0] ROM_BASE_DEF  = 36'h1_0000_0000;
  localparam int          ROM_WORDS_DEF = 46;
  localparam int          WIDX_W        = 33;

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Per-requester burst-read port: request channel plus registered response channel.
interface rom_fetch_arbiter_if #(
  parameter int LEN_W = 3
);

  logic             req_valid;
  logic             req_ready;
  logic [35:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic             rsp_last;
  logic             rsp_err;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

endinterface

// File: rtl/rom_fetch_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer remembers which requester was served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // 1 = requester 1 was served last, so requester 0 wins a tie (reset state).
  logic last_1_q;

  assign gnt[0] = req[0] & (~req[1] |  last_1_q);
  assign gnt[1] = req[1] & (~req[0] | ~last_1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_1_q <= 1'b1;
    end else if (accept) begin
      last_1_q <= gnt[1];
    end
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Round-robin burst sequencer in front of the boot ROM: one word per cycle into a
// registered, backpressured response slot owned by the granted requester.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter logic [35:0] ROM_BASE  = ROM_BASE_DEF,
  parameter int          ROM_WORDS = ROM_WORDS_DEF,
  parameter int          LEN_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_fetch_arbiter_if.slave  if_bus,
  rom_fetch_arbiter_if.slave  dm_bus,
  output logic [35:0]         rom_addr,
  input  logic [63:0]         rom_data
);

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   waddr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                owner_q;   // 0 = if, 1 = dm
  logic                vld_q, last_q, err_q;
  logic [63:0]         data_q;

  logic [1:0]          req, gnt;
  logic                accept, load, own_ready, in_win;

  // One bit wider than the word index so base+words cannot wrap at the top of memory.
  function automatic logic in_window(input logic [WIDX_W-1:0] w);
    logic [WIDX_W:0] lo, hi, wx;
    lo = {1'b0, ROM_BASE[35:3]};
    hi = lo + (WIDX_W+1)'(ROM_WORDS);
    wx = {1'b0, w};
    return (wx >= lo) && (wx < hi);
  endfunction

  assign req = {dm_bus.req_valid, if_bus.req_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign accept           = (state_q == ST_IDLE) && (req != 2'b00);
  assign if_bus.req_ready = (state_q == ST_IDLE) && gnt[0];
  assign dm_bus.req_ready = (state_q == ST_IDLE) && gnt[1];

  assign own_ready = owner_q ? dm_bus.rsp_ready : if_bus.rsp_ready;
  assign load      = (state_q == ST_BURST) && (!vld_q || own_ready);
  assign in_win    = in_window(waddr_q);
  assign rom_addr  = (state_q == ST_BURST) ? {waddr_q, 3'b000} : 36'd0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_BURST;
      ST_BURST: if (load && (cnt_q == '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (own_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Burst bookkeeping and the single shared response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        waddr_q <= gnt[1] ? dm_bus.req_addr[35:3] : if_bus.req_addr[35:3];
        cnt_q   <= gnt[1] ? dm_bus.req_len : if_bus.req_len;
        owner_q <= gnt[1];
      end
      if (load) begin
        vld_q   <= 1'b1;
        data_q  <= in_win ? rom_data : 64'd0;
        err_q   <= !in_win;
        last_q  <= (cnt_q == '0);
        waddr_q <= waddr_q + WIDX_W'(1);
        cnt_q   <= cnt_q - LEN_W'(1);
      end else if ((state_q == ST_DRAIN) && own_ready) begin
        vld_q   <= 1'b0;
        data_q  <= '0;
        last_q  <= 1'b0;
        err_q   <= 1'b0;
      end
    end
  end

  // Only the owner sees the slot; the other port reads all zeros.
  assign if_bus.rsp_valid = vld_q  & ~owner_q;
  assign if_bus.rsp_last  = last_q & ~owner_q;
  assign if_bus.rsp_err   = err_q  & ~owner_q;
  assign if_bus.rsp_data  = owner_q ? 64'd0 : data_q;
  assign dm_bus.rsp_valid = vld_q  & owner_q;
  assign dm_bus.rsp_last  = last_q & owner_q;
  assign dm_bus.rsp_err   = err_q  & owner_q;
  assign dm_bus.rsp_data  = owner_q ? data_q : 64'd0;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a small ROM model and a response collector.
module tb_rom_fetch_arbiter;

  localparam logic [63:0] W0  = 64'h1400004f_040000ff;
  localparam logic [63:0] W1  = 64'h17000a01_1900474e;
  localparam logic [63:0] W2  = 64'h17003a41_00380180;
  localparam logic [63:0] W3  = 64'h1900638e_03000037;
  localparam logic [63:0] W4  = 64'h1900630e_00010731;
  localparam logic [63:0] W45 = 64'h20202020_4e206279;

  typedef struct packed {
    logic        port;
    logic        last;
    logic        err;
    logic [63:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] rom_addr;
  logic [63:0] rom_data;
  int          n_chk = 0;
  int          n_fail = 0;
  rsp_t        rq[$];
  int          order[$];

  rom_fetch_arbiter_if #(.LEN_W(3)) ifb ();
  rom_fetch_arbiter_if #(.LEN_W(3)) dmb ();

  rom_fetch_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_bus   (ifb),
    .dm_bus   (dmb),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input logic [35:0] a);
    logic [32:0] w;
    w = a[35:3] - 33'h0_2000_0000;
    case (w)
      33'd0:   return W0;
      33'd1:   return W1;
      33'd2:   return W2;
      33'd3:   return W3;
      33'd4:   return W4;
      33'd45:  return W45;
      default: return {32'hC0DE_0000 | w[31:0], ~w[31:0]};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifb.rsp_valid && ifb.rsp_ready) rq.push_back({1'b0, ifb.rsp_last, ifb.rsp_err, ifb.rsp_data});
      if (dmb.rsp_valid && dmb.rsp_ready) rq.push_back({1'b1, dmb.rsp_last, dmb.rsp_err, dmb.rsp_data});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic rsp_t rq_at(input int i);
    rsp_t bad;
    bad = '1;
    if (i < rq.size()) return rq[i];
    return bad;
  endfunction

  // Issue one request and return in the cycle after it is accepted.
  task automatic do_req(input bit port, input logic [35:0] addr, input logic [2:0] len);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (port) begin dmb.req_valid = 1'b1; dmb.req_addr = addr; dmb.req_len = len; end
    else      begin ifb.req_valid = 1'b1; ifb.req_addr = addr; ifb.req_len = len; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? dmb.req_ready : ifb.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
    dmb.req_valid = 1'b0;
    if (!got) chk("req_accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_rsp(input string tag, input int n);
    for (int i = 0; i < 100 && rq.size() < n; i++) @(negedge clk);
    chk(tag, 64'(rq.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rsp_t e;
    ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.req_len = '0; ifb.rsp_ready = 1'b1;
    dmb.req_valid = 1'b0; dmb.req_addr = '0; dmb.req_len = '0; dmb.rsp_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_if_valid", 64'(ifb.rsp_valid), 64'd0);
    chk("rst_dm_valid", 64'(dmb.rsp_valid), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_if_data", ifb.rsp_data, 64'd0);
    #11 rst_n = 1'b1;

    // Single read with latency checks
    @(posedge clk); #1;
    ifb.req_valid = 1'b1; ifb.req_addr = 36'h1_0000_0000; ifb.req_len = 3'd0;
    @(negedge clk);
    chk("single_if_ready", 64'(ifb.req_ready), 64'd1);
    chk("single_dm_ready", 64'(dmb.req_ready), 64'd0);
    @(posedge clk); #1 ifb.req_valid = 1'b0;
    @(negedge clk);
    chk("single_t1_valid", 64'(ifb.rsp_valid), 64'd0);
    chk("single_t1_rom_addr", 64'(rom_addr), 64'h1_0000_0000);
    @(negedge clk);
    chk("single_t2_valid", 64'(ifb.rsp_valid), 64'd1);
    chk("single_t2_data", ifb.rsp_data, W0);
    chk("single_t2_last", 64'(ifb.rsp_last), 64'd1);
    chk("single_t2_err", 64'(ifb.rsp_err), 64'd0);
    chk("single_t2_dm_valid", 64'(dmb.rsp_valid), 64'd0);
    @(negedge clk);
    chk("single_t3_valid", 64'(ifb.rsp_valid), 64'd0);
    rq.delete();

    // Misaligned address selects the same word
    do_req(1'b0, 36'h1_0000_0007, 3'd0);
    wait_rsp("misalign_count", 1);
    chk("misalign_data", rq_at(0).data, W0);
    rq.delete();

    // Burst with backpressure on dm
    do_req(1'b1, 36'h1_0000_0008, 3'd3);
    @(negedge clk);
    @(negedge clk);
    chk("bp_w1_data", dmb.rsp_data, W1);
    @(negedge clk);
    chk("bp_w2_data", dmb.rsp_data, W2);
    @(posedge clk); #1 dmb.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_data", k), dmb.rsp_data, W3);
      chk($sformatf("bp_stall%0d_valid", k), 64'(dmb.rsp_valid), 64'd1);
      chk($sformatf("bp_stall%0d_last", k), 64'(dmb.rsp_last), 64'd0);
    end
    chk("bp_stall_rom_addr", 64'(rom_addr), 64'h1_0000_0020);
    chk("bp_nonowner_data", ifb.rsp_data, 64'd0);
    @(posedge clk); #1 dmb.rsp_ready = 1'b1;
    wait_rsp("bp_count", 4);
    repeat (3) @(negedge clk);
    chk("bp_no_dup", 64'(rq.size()), 64'd4);
    chk("bp_q0", 64'(rq_at(0).data), W1);
    chk("bp_q1", 64'(rq_at(1).data), W2);
    chk("bp_q2", 64'(rq_at(2).data), W3);
    chk("bp_q3", 64'(rq_at(3).data), W4);
    chk("bp_lasts", 64'({rq_at(0).last, rq_at(1).last, rq_at(2).last, rq_at(3).last}), 64'b0001);
    chk("bp_port", 64'(rq_at(3).port), 64'd1);
    rq.delete();

    // Contention right after reset: held requests alternate if, dm, if
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ifb.req_valid = 1'b1; ifb.req_addr = 36'h1_0000_0000; ifb.req_len = 3'd0;
    dmb.req_valid = 1'b1; dmb.req_addr = 36'h1_0000_0008; dmb.req_len = 3'd0;
    for (int i = 0; i < 60 && order.size() < 3; i++) begin
      @(negedge clk);
      if (ifb.req_ready) order.push_back(0);
      if (dmb.req_ready) order.push_back(1);
    end
    @(posedge clk); #1;
    ifb.req_valid = 1'b0; dmb.req_valid = 1'b0;
    chk("rr_grants", 64'(order.size()), 64'd3);
    if (order.size() == 3) chk("rr_order", 64'({order[0][0], order[1][0], order[2][0]}), 64'b010);
    wait_rsp("rr_rsp_count", 3);
    e = rq_at(1);
    chk("rr_rsp0", {63'd0, rq_at(0).port} ^ rq_at(0).data, W0);
    chk("rr_rsp1", {63'd0, e.port} ^ e.data, W1 ^ 64'd1);
    chk("rr_rsp2", {63'd0, rq_at(2).port} ^ rq_at(2).data, W0);
    rq.delete();

    // Window edges
    do_req(1'b0, 36'h0, 3'd0);
    wait_rsp("win_low_count", 1);
    chk("win_low_data", rq_at(0).data, 64'd0);
    chk("win_low_err_last", 64'({rq_at(0).err, rq_at(0).last}), 64'b11);
    rq.delete();
    do_req(1'b1, 36'h1_0000_0168, 3'd1);
    wait_rsp("win_end_count", 2);
    chk("win_end_w0_data", rq_at(0).data, W45);
    chk("win_end_w0_err_last", 64'({rq_at(0).err, rq_at(0).last}), 64'b00);
    chk("win_end_w1_data", rq_at(1).data, 64'd0);
    chk("win_end_w1_err_last", 64'({rq_at(1).err, rq_at(1).last}), 64'b11);
    rq.delete();

    // Reset during word 2 of an 8-word burst
    do_req(1'b1, 36'h1_0000_0000, 3'd7);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_w1_valid", 64'(dmb.rsp_valid), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(dmb.rsp_valid), 64'd0);
    chk("rstmid_data", dmb.rsp_data, 64'd0);
    chk("rstmid_last_err", 64'({dmb.rsp_last, dmb.rsp_err}), 64'd0);
    chk("rstmid_rom_addr", 64'(rom_addr), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rq.delete();
    do_req(1'b1, 36'h1_0000_0010, 3'd0);
    wait_rsp("rstmid_new_count", 1);
    repeat (4) @(negedge clk);
    chk("rstmid_no_leftover", 64'(rq.size()), 64'd1);
    chk("rstmid_new_data", rq_at(0).data, W2);
    chk("rstmid_new_flags", 64'({rq_at(0).port, rq_at(0).last, rq_at(0).err}), 64'b110);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
